// File: rtl/motor_pkg.sv
// Shared types and parameter defaults for the motor step generator.
package motor_pkg;

   localparam int unsigned CntWDefault     = 32;
   localparam int unsigned PulseWDefault   = 4;
   localparam int unsigned DirSetupDefault = 8;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StHigh,
      StLow,
      StDone
   } state_e;

endpackage

// File: rtl/motor_step_gen_if.sv
// Move-command handshake between the register bank (master) and the step generator (slave).
interface motor_step_gen_if
   import motor_pkg::*;
#(
   parameter int unsigned CNT_W = CntWDefault
) ();

   logic             cmd_valid;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_steps;
   logic [CNT_W-1:0] cmd_period;
   logic             cmd_dir;

   modport master (
      output cmd_valid, cmd_steps, cmd_period, cmd_dir,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_steps, cmd_period, cmd_dir,
      output cmd_ready
   );

endinterface

// File: rtl/motor_phase_timer.sv
// Loadable down-counter shared by the SETUP, HIGH and LOW phases; zero marks the last phase cycle.
module motor_phase_timer
   import motor_pkg::*;
#(
   parameter int unsigned CNT_W = CntWDefault
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/motor_step_gen.sv
// Step/direction pulse generator: accepts a move command and emits timed step pulses.
module motor_step_gen
   import motor_pkg::*;
#(
   parameter int unsigned CNT_W     = CntWDefault,
   parameter int unsigned PULSE_W   = PulseWDefault,
   parameter int unsigned DIR_SETUP = DirSetupDefault
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   motor_step_gen_if.slave  cmd,
   input  logic             abort,
   output logic             step_out,
   output logic             dir_out,
   output logic             busy,
   output logic [CNT_W-1:0] steps_done,
   output logic             done_pulse,
   output logic             err_period
);

   // Timer loads are length-1 because the zero cycle is the last cycle of a phase.
   localparam logic [CNT_W-1:0] MinPeriod = CNT_W'(2 * PULSE_W);
   localparam logic [CNT_W-1:0] SetupLoad = CNT_W'(DIR_SETUP - 1);
   localparam logic [CNT_W-1:0] HighLoad  = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] LowOffset = CNT_W'(PULSE_W + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] steps_q, steps_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
   logic             dir_q, dir_d;
   logic             err_q, err_d;
   logic             step_q;
   logic             accept;
   logic             tmr_load, tmr_zero;
   logic [CNT_W-1:0] tmr_val;

   assign cmd.cmd_ready = (state_q == StIdle) && !abort;
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;

   always_comb begin
      state_d    = state_q;
      steps_d    = steps_q;
      period_d   = period_q;
      done_cnt_d = done_cnt_q;
      dir_d      = dir_q;
      err_d      = 1'b0;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               steps_d    = cmd.cmd_steps;
               period_d   = cmd.cmd_period;
               done_cnt_d = '0;
               if (cmd.cmd_period < MinPeriod) begin
                  err_d = 1'b1;
               end else begin
                  dir_d    = cmd.cmd_dir;
                  tmr_load = 1'b1;
                  // A zero-step move idles one LOW cycle so its done strobe follows acceptance by two.
                  if (cmd.cmd_steps == '0) begin
                     state_d = StLow;
                  end else begin
                     state_d = StSetup;
                     tmr_val = SetupLoad;
                  end
               end
            end
         end
         StSetup: begin
            if (abort) begin
               state_d = StDone;
            end else if (tmr_zero) begin
               state_d    = StHigh;
               tmr_load   = 1'b1;
               tmr_val    = HighLoad;
               done_cnt_d = done_cnt_q + CNT_W'(1);
            end
         end
         StHigh: begin
            if (abort) begin
               state_d = StDone;
            end else if (tmr_zero) begin
               state_d  = StLow;
               tmr_load = 1'b1;
               tmr_val  = period_q - LowOffset;
            end
         end
         StLow: begin
            if (abort) begin
               state_d = StDone;
            end else if (tmr_zero) begin
               if (done_cnt_q < steps_q) begin
                  state_d    = StHigh;
                  tmr_load   = 1'b1;
                  tmr_val    = HighLoad;
                  done_cnt_d = done_cnt_q + CNT_W'(1);
               end else begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= StIdle;
         steps_q    <= '0;
         period_q   <= '0;
         done_cnt_q <= '0;
         dir_q      <= 1'b0;
         err_q      <= 1'b0;
         step_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         steps_q    <= steps_d;
         period_q   <= period_d;
         done_cnt_q <= done_cnt_d;
         dir_q      <= dir_d;
         err_q      <= err_d;
         step_q     <= (state_d == StHigh);
      end
   end

   motor_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .ACLK     (ACLK),
      .ARESETN  (ARESETN),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   assign step_out   = step_q;
   assign dir_out    = dir_q;
   assign busy       = (state_q != StIdle);
   assign steps_done = done_cnt_q;
   assign done_pulse = (state_q == StDone);
   assign err_period = err_q;

endmodule

// File: tb/tb_motor_step_gen.sv
// Directed bench for motor_step_gen with PULSE_W=4, DIR_SETUP=8; timelines counted in edges after acceptance.
module tb_motor_step_gen;

   logic        tb_ACLK = 1'b0;
   logic        tb_ARESETN = 1'b1;
   logic        abort;
   logic        step_out;
   logic        dir_out;
   logic        busy;
   logic [31:0] steps_done;
   logic        done_pulse;
   logic        err_period;

   int n_checks = 0;
   int n_fail   = 0;

   motor_step_gen_if #(.CNT_W(32)) cmd_if ();

   motor_step_gen #(
      .CNT_W     (32),
      .PULSE_W   (4),
      .DIR_SETUP (8)
   ) dut (
      .ACLK       (tb_ACLK),
      .ARESETN    (tb_ARESETN),
      .cmd        (cmd_if),
      .abort      (abort),
      .step_out   (step_out),
      .dir_out    (dir_out),
      .busy       (busy),
      .steps_done (steps_done),
      .done_pulse (done_pulse),
      .err_period (err_period)
   );

   always #5 tb_ACLK = ~tb_ACLK;

   task automatic tick();
      @(posedge tb_ACLK);
      #1;
   endtask

   // Offers one command for one edge; returns 1 ns after the accepting edge.
   task automatic issue(input logic [31:0] steps, input logic [31:0] period, input logic dir);
      cmd_if.cmd_steps  = steps;
      cmd_if.cmd_period = period;
      cmd_if.cmd_dir    = dir;
      cmd_if.cmd_valid  = 1'b1;
      n_checks++;
      if (cmd_if.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL issue_ready: got %b want 1", cmd_if.cmd_ready);
      end
      tick();
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      cmd_if.cmd_valid = 1'b0; cmd_if.cmd_steps = '0; cmd_if.cmd_period = '0;
      cmd_if.cmd_dir = 1'b0; abort = 1'b0;
      #2 tb_ARESETN = 1'b0;
      #1;
      n_checks++;
      if ({step_out, dir_out, busy, done_pulse, err_period} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 00000",
                  {step_out, dir_out, busy, done_pulse, err_period});
      end
      n_checks++;
      if (steps_done !== 32'd0) begin
         n_fail++; $display("FAIL reset_steps_done: got %0d want 0", steps_done);
      end
      tick(); tick();
      tb_ARESETN = 1'b1;
      #1;
      n_checks++;
      if (cmd_if.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_if.cmd_ready);
      end
      tick();
   endtask

   // 3 steps, period 10: SETUP edges 0..7, HIGH at 8/18/28 for 4, DONE at 38, IDLE at 39.
   task automatic test_single_move();
      logic [2:0] exp_v;
      int         exp_cnt;
      issue(32'd3, 32'd10, 1'b1);
      n_checks++;
      if ({dir_out, busy, step_out} !== 3'b110) begin
         n_fail++; $display("FAIL move_start: dir,busy,step got %b want 110", {dir_out, busy, step_out});
      end
      for (int k = 1; k <= 39; k++) begin
         tick();
         exp_v[2] = (k >= 8 && k < 38 && ((k - 8) % 10) < 4);
         exp_v[1] = (k == 38);
         exp_v[0] = (k <= 38);
         exp_cnt  = (k < 8) ? 0 : (k >= 38) ? 3 : ((k - 8) / 10 + 1);
         n_checks++;
         if ({step_out, done_pulse, busy} !== exp_v) begin
            n_fail++;
            $display("FAIL move_wave k=%0d: step,done,busy got %b want %b",
                     k, {step_out, done_pulse, busy}, exp_v);
         end
         n_checks++;
         if (steps_done !== 32'(exp_cnt)) begin
            n_fail++; $display("FAIL move_count k=%0d: got %0d want %0d", k, steps_done, exp_cnt);
         end
      end
   endtask

   task automatic test_zero_steps();
      issue(32'd0, 32'd10, 1'b0);
      n_checks++;
      if ({dir_out, busy, done_pulse, step_out} !== 4'b0100 || steps_done !== 32'd0) begin
         n_fail++;
         $display("FAIL zero_e0: dir,busy,done,step got %b cnt %0d want 0100 cnt 0",
                  {dir_out, busy, done_pulse, step_out}, steps_done);
      end
      tick();
      n_checks++;
      if ({busy, done_pulse, step_out} !== 3'b110) begin
         n_fail++; $display("FAIL zero_e1: busy,done,step got %b want 110", {busy, done_pulse, step_out});
      end
      tick();
      n_checks++;
      if ({busy, done_pulse, cmd_if.cmd_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL zero_e2: busy,done,ready got %b want 001", {busy, done_pulse, cmd_if.cmd_ready});
      end
   endtask

   task automatic test_bad_period();
      issue(32'd5, 32'd7, 1'b1);
      n_checks++;
      if ({err_period, busy, dir_out, step_out} !== 4'b1000) begin
         n_fail++;
         $display("FAIL badper_e0: err,busy,dir,step got %b want 1000",
                  {err_period, busy, dir_out, step_out});
      end
      tick();
      n_checks++;
      if ({err_period, busy, dir_out} !== 3'b000) begin
         n_fail++; $display("FAIL badper_e1: err,busy,dir got %b want 000", {err_period, busy, dir_out});
      end
      // Period exactly 2*PULSE_W is the smallest legal value.
      issue(32'd0, 32'd8, 1'b1);
      n_checks++;
      if ({err_period, busy, dir_out} !== 3'b011) begin
         n_fail++; $display("FAIL minper_e0: err,busy,dir got %b want 011", {err_period, busy, dir_out});
      end
      tick();
      n_checks++;
      if (done_pulse !== 1'b1) begin
         n_fail++; $display("FAIL minper_done: got %b want 1", done_pulse);
      end
      tick();
   endtask

   // Period 20: third HIGH spans edges 48..51; abort is raised after edge 49.
   task automatic test_abort();
      issue(32'd100, 32'd20, 1'b0);
      repeat (49) tick();
      n_checks++;
      if (step_out !== 1'b1 || steps_done !== 32'd3) begin
         n_fail++; $display("FAIL abort_pre: step %b cnt %0d want 1 cnt 3", step_out, steps_done);
      end
      abort = 1'b1;
      tick();
      n_checks++;
      if ({step_out, done_pulse, busy} !== 3'b011 || steps_done !== 32'd3) begin
         n_fail++;
         $display("FAIL abort_e50: step,done,busy got %b cnt %0d want 011 cnt 3",
                  {step_out, done_pulse, busy}, steps_done);
      end
      tick();
      n_checks++;
      if ({busy, done_pulse, cmd_if.cmd_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL abort_idle: busy,done,ready got %b want 000", {busy, done_pulse, cmd_if.cmd_ready});
      end
      cmd_if.cmd_steps = 32'd1; cmd_if.cmd_period = 32'd10; cmd_if.cmd_dir = 1'b1;
      cmd_if.cmd_valid = 1'b1;
      tick();
      n_checks++;
      if ({busy, dir_out} !== 2'b00) begin
         n_fail++; $display("FAIL abort_block: busy,dir got %b want 00", {busy, dir_out});
      end
      cmd_if.cmd_valid = 1'b0;
      abort = 1'b0;
      #1;
      n_checks++;
      if (cmd_if.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL abort_ready: got %b want 1", cmd_if.cmd_ready);
      end
      tick();
   endtask

   task automatic test_reset_mid_move();
      issue(32'd10, 32'd10, 1'b1);
      repeat (14) tick();
      n_checks++;
      if ({step_out, busy, dir_out} !== 3'b011 || steps_done !== 32'd1) begin
         n_fail++;
         $display("FAIL rst_pre: step,busy,dir got %b cnt %0d want 011 cnt 1",
                  {step_out, busy, dir_out}, steps_done);
      end
      #2 tb_ARESETN = 1'b0;
      #1;
      n_checks++;
      if ({step_out, dir_out, busy, done_pulse, err_period} !== 5'b0 || steps_done !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_async: outs got %b cnt %0d want 00000 cnt 0",
                  {step_out, dir_out, busy, done_pulse, err_period}, steps_done);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++;
         if ({done_pulse, busy} !== 2'b00) begin
            n_fail++; $display("FAIL rst_hold k=%0d: done,busy got %b want 00", k, {done_pulse, busy});
         end
      end
      tb_ARESETN = 1'b1;
      #1;
      issue(32'd1, 32'd8, 1'b0);
      n_checks++;
      if ({busy, dir_out} !== 2'b10) begin
         n_fail++; $display("FAIL rst_new_cmd: busy,dir got %b want 10", {busy, dir_out});
      end
      for (int k = 1; k <= 17; k++) begin
         tick();
         n_checks++;
         if ({step_out, done_pulse} !== {1'(k >= 8 && k < 12), 1'(k == 16)}) begin
            n_fail++;
            $display("FAIL rst_move k=%0d: step,done got %b want %b", k, {step_out, done_pulse},
                     {1'(k >= 8 && k < 12), 1'(k == 16)});
         end
      end
      n_checks++;
      if (steps_done !== 32'd1) begin
         n_fail++; $display("FAIL rst_move_count: got %0d want 1", steps_done);
      end
   endtask

   // 2 steps, period 8: DONE at edge 24, IDLE after 25, so the held command re-accepts at edge 26.
   task automatic test_back_to_back();
      int n_acc = 0;
      int first_acc = -1;
      int second_acc = -1;
      cmd_if.cmd_steps = 32'd2; cmd_if.cmd_period = 32'd8; cmd_if.cmd_dir = 1'b1;
      cmd_if.cmd_valid = 1'b1;
      for (int e = 0; e <= 30; e++) begin
         if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            n_acc++;
            if (n_acc == 1) first_acc = e;
            else if (n_acc == 2) second_acc = e;
         end
         tick();
         if (n_acc == 2) break;
      end
      cmd_if.cmd_valid = 1'b0;
      n_checks++;
      if (first_acc != 0 || second_acc != 26) begin
         n_fail++;
         $display("FAIL b2b_accept: edges %0d,%0d want 0,26", first_acc, second_acc);
      end
      n_checks++;
      if ({busy, dir_out} !== 2'b11 || steps_done !== 32'd0) begin
         n_fail++;
         $display("FAIL b2b_restart: busy,dir got %b cnt %0d want 11 cnt 0", {busy, dir_out}, steps_done);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL b2b_end: busy got %b want 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_single_move();
      test_zero_steps();
      test_bad_period();
      test_abort();
      test_reset_mid_move();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/motor_step_gen.md
MOTOR_STEP_GEN -- requirements
Module: motor_step_gen

Interface
REQ-001 Parameter CNT_W, default 32: width of the step count, period and timer fields.
REQ-002 Parameter PULSE_W, default 4: high time of each step pulse, in ACLK cycles; legal range 1..255.
REQ-003 Parameter DIR_SETUP, default 8: cycles between dir_out settling and the first step edge; legal range 1..255.
REQ-004 ACLK  in  1  single clock; all logic is on the rising edge.
REQ-005 ARESETN  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  move command offered by the AXI-Lite motor register bank.
REQ-007 cmd_ready  out  1  the block can accept a command.
REQ-008 cmd_steps  in  CNT_W  number of steps to issue.
REQ-009 cmd_period  in  CNT_W  ACLK cycles from one step rising edge to the next.
REQ-010 cmd_dir  in  1  direction: 1 = forward, 0 = reverse.
REQ-011 abort  in  1  level stop request.
REQ-012 step_out  out  1  step pulse to the motor driver.
REQ-013 dir_out  out  1  registered direction to the motor driver.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 steps_done  out  CNT_W  steps issued for the current or last command.
REQ-016 done_pulse  out  1  one-cycle completion or abort strobe.
REQ-017 err_period  out  1  one-cycle strobe: command rejected because the period is illegal.

Function
REQ-018 The state machine SHALL have the states IDLE, SETUP, HIGH, LOW and DONE.
REQ-019 cmd_ready SHALL equal (state==IDLE && !abort); a command is accepted on a rising edge where cmd_valid && cmd_ready.
REQ-020 On acceptance, the block SHALL latch cmd_steps, cmd_period and cmd_dir, load dir_out from cmd_dir, and clear steps_done.
REQ-021 Acceptance with cmd_period < 2*PULSE_W SHALL pulse err_period for one cycle, produce no step, leave dir_out unchanged, and return to IDLE.
REQ-022 Acceptance with cmd_steps==0 and a legal period SHALL go to DONE, with no step.
REQ-023 Any other acceptance SHALL go to SETUP; SETUP lasts DIR_SETUP cycles, then goes to HIGH.
REQ-024 HIGH lasts PULSE_W cycles with step_out=1.
REQ-025 steps_done SHALL increment by 1 on the cycle HIGH is entered.
REQ-026 LOW lasts cmd_period-PULSE_W cycles with step_out=0.
REQ-027 At the end of LOW, the block SHALL go to HIGH if steps_done < latched steps, otherwise to DONE.
REQ-028 DONE lasts one cycle with done_pulse=1, then goes to IDLE.
REQ-029 step_out SHALL be driven directly from a register, with no combinational path from any input.
REQ-030 abort=1 in SETUP, HIGH or LOW SHALL force step_out=0 and go to DONE on the next edge; steps_done holds its value.
REQ-031 abort in IDLE or DONE has no effect other than holding cmd_ready low.
REQ-032 cmd_valid outside IDLE SHALL be ignored; no command is queued.
REQ-033 dir_out SHALL change only on an accepted, legal command.
REQ-034 steps_done never exceeds the latched step count; no wrap-around is possible.
REQ-035 Period and phase timers SHALL be CNT_W-bit down-counters; cmd_period up to 2^CNT_W-1 is legal.

Reset
REQ-036 ARESETN low SHALL force, asynchronously: state=IDLE, step_out=0, dir_out=0, busy=0, steps_done=0, done_pulse=0, err_period=0.
REQ-037 After reset, cmd_ready=1 on the first edge with ARESETN high.
REQ-038 Reset asserted mid-move SHALL abandon the move; no done_pulse is generated.

Structure
REQ-039 Package motor_pkg SHALL hold the state enumeration type, the CNT_W default, and the PULSE_W and DIR_SETUP defaults.
REQ-040 One sub-module, motor_phase_timer, SHALL be used: a loadable down-counter with load and zero-flag outputs, shared by SETUP, HIGH and LOW.

Verification
REQ-041 steps=3, period=10, dir=1, PULSE_W=4, DIR_SETUP=8 -> dir_out=1 one cycle after acceptance; first step rise 8 cycles later; 3 pulses, each 4 high / 6 low; done_pulse one cycle after the last LOW; steps_done=3.
REQ-042 steps=0, period=10 -> no step; done_pulse exactly 2 cycles after acceptance; steps_done=0.
REQ-043 steps=5, period=7 (less than 8) -> err_period one cycle; no step; busy stays 0; dir_out unchanged.
REQ-044 steps=100, period=20, abort raised during the 3rd HIGH -> step_out=0 on the next edge; done_pulse; steps_done=3; cmd_ready=1 after abort drops.
REQ-045 ARESETN dropped mid-LOW of a 10-step move -> all outputs reach reset values immediately; no done_pulse; a new command is accepted after release.
REQ-046 cmd_valid held high through a 2-step move -> only one acceptance during the move; the next acceptance occurs on the first IDLE cycle after DONE.
